// File: rtl/exc_commit_unit_pkg.sv
// exc_commit_unit_pkg: exception codes, CP0 register addresses, field indices and shared types
package exc_commit_unit_pkg;
  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;
  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int IRQ_LO     = 8;
  localparam int IRQ_HI     = 15;
  localparam logic [31:0] EXC_NONE = 32'h00;
  localparam logic [31:0] EXC_INT  = 32'h01;
  localparam logic [31:0] EXC_ADEL = 32'h04;
  localparam logic [31:0] EXC_ADES = 32'h05;
  localparam logic [31:0] EXC_SYS  = 32'h08;
  localparam logic [31:0] EXC_BP   = 32'h09;
  localparam logic [31:0] EXC_RI   = 32'h0a;
  localparam logic [31:0] EXC_OV   = 32'h0c;
  localparam logic [31:0] EXC_TR   = 32'h0d;
  localparam logic [31:0] EXC_ERET = 32'h0e;
  localparam int F_RI      = 0;
  localparam int F_OV      = 1;
  localparam int F_SYS     = 2;
  localparam int F_BRK     = 3;
  localparam int F_TRAP    = 4;
  localparam int F_ERET    = 5;
  localparam int F_ADEL_LD = 6;
  localparam int F_ADES    = 7;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  typedef enum logic [1:0] {BAD_NONE, BAD_PC, BAD_MEM} bad_sel_e;
  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] newpc;
  } exc_rec_t;
endpackage

// File: rtl/exc_commit_unit_prio_enc.sv
// exc_prio_enc: resolves interrupt and exception flags to a single code plus BadVAddr source
module exc_prio_enc
  import exc_commit_unit_pkg::*;
(
  input  logic        int_i,
  input  logic        adel_if_i,
  input  logic [7:0]  flags_i,
  output logic [31:0] code_o,
  output bad_sel_e    bad_sel_o
);
  always_comb begin
    code_o = int_i                ? EXC_INT  :
             adel_if_i            ? EXC_ADEL :
             flags_i[F_RI]        ? EXC_RI   :
             flags_i[F_OV]        ? EXC_OV   :
             flags_i[F_SYS]       ? EXC_SYS  :
             flags_i[F_BRK]       ? EXC_BP   :
             flags_i[F_TRAP]      ? EXC_TR   :
             flags_i[F_ERET]      ? EXC_ERET :
             flags_i[F_ADEL_LD]   ? EXC_ADEL :
             flags_i[F_ADES]      ? EXC_ADES : EXC_NONE;
    bad_sel_o = int_i                      ? BAD_NONE :
                adel_if_i                  ? BAD_PC   :
                |flags_i[F_ERET:F_RI]      ? BAD_NONE :
                |flags_i[F_ADES:F_ADEL_LD] ? BAD_MEM  : BAD_NONE;
  end
endmodule

// File: rtl/exc_commit_unit.sv
// exc_commit_unit: MEM-stage exception arbiter feeding CP0, with stall hold and pipeline flush/redirect
module exc_commit_unit
  import exc_commit_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        inst_valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  exc_flags_i,
  input  logic        adel_if_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  exc_rec_t      rec_q, rec_d, cur, out;
  logic [31:0]   status_f, cause_f, epc_f, code, bad;
  logic          int_pend, flush, unused_ok;
  bad_sel_e      bad_sel;
  // Cause is only software-writable in IP[9:8]; the rest comes from the register
  assign status_f = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_STATUS) ? wb_cp0_wdata_i : cp0_status_i;
  assign cause_f  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_CAUSE)
                    ? {cp0_cause_i[31:10], wb_cp0_wdata_i[9:8], cp0_cause_i[7:0]} : cp0_cause_i;
  assign epc_f    = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_REG_EPC) ? wb_cp0_wdata_i : cp0_epc_i;
  assign int_pend = status_f[STATUS_IE] & ~status_f[STATUS_EXL]
                    & |(cause_f[IRQ_HI:IRQ_LO] & status_f[IRQ_HI:IRQ_LO]);
  assign unused_ok = ^{status_f[31:16], status_f[7:2], cause_f[31:16], cause_f[7:0]};
  exc_prio_enc u_enc (
    .int_i     (inst_valid_i & int_pend),
    .adel_if_i (inst_valid_i & adel_if_i),
    .flags_i   (inst_valid_i ? exc_flags_i : 8'h00),
    .code_o    (code),
    .bad_sel_o (bad_sel)
  );
  assign bad = bad_sel == BAD_PC ? pc_i : bad_sel == BAD_MEM ? mem_addr_i : 32'h0;
  assign cur = '{code: code, pc: pc_i, ds: in_delayslot_i, bad: bad,
                 newpc: code == EXC_ERET ? epc_f : EXC_VECTOR};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;
    out     = '0;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: if (code != EXC_NONE) begin
        rec_d = cur;
        if (stall_i) state_d = ST_HOLD;
        else begin
          out   = cur;
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_HOLD: if (!stall_i) begin
        out     = rec_q;
        flush   = 1'b1;
        state_d = FLUSH_CYCLES > 1 ? ST_FLUSH : ST_IDLE;
        cnt_d   = FLUSH_CYCLES > 1 ? CW'(1) : '0;
      end
      ST_FLUSH: begin
        out.newpc = rec_q.newpc;
        flush     = 1'b1;
        state_d   = cnt_q == CW'(FLUSH_CYCLES - 1) ? ST_IDLE : ST_FLUSH;
        cnt_d     = cnt_q == CW'(FLUSH_CYCLES - 1) ? '0 : cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rec_q   <= rec_d;
    end
  end
  assign excepttype_o        = rst ? out.code : '0;
  assign current_inst_addr_o = rst ? out.pc : '0;
  assign is_in_delayslot_o   = rst & out.ds;
  assign bad_addr_o          = rst ? out.bad : '0;
  assign flush_o             = rst & flush;
  assign newpc_o             = rst ? out.newpc : '0;
endmodule

// File: tb/tb_exc_commit_unit.sv
// tb_exc_commit_unit: scoreboard bench; stimulus queues expected pulses, monitors pop and compare
module tb_exc_commit_unit;
  localparam logic [31:0] VEC = 32'hBFC00380;
  typedef struct {
    logic [31:0] code;
    logic [31:0] addr;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] newpc;
  } exp_t;
  logic clk = 0, rst = 0, stall = 0, valid = 0, valid3 = 0, ds = 0, adel_if = 0, we = 0;
  logic [31:0] pc = 0, mem = 0, status = 0, cause = 0, epc = 0, wdata = 0;
  logic [7:0]  flags = 0;
  logic [4:0]  waddr = 0;
  logic [31:0] et1, addr1, bad1, np1, et3, addr3, bad3, np3;
  logic        ids1, fl1, ids3, fl3;
  exp_t q1[$], q3[$];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  exc_commit_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall), .inst_valid_i(valid), .pc_i(pc),
    .in_delayslot_i(ds), .mem_addr_i(mem), .exc_flags_i(flags), .adel_if_i(adel_if),
    .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(we),
    .wb_cp0_waddr_i(waddr), .wb_cp0_wdata_i(wdata), .excepttype_o(et1),
    .current_inst_addr_o(addr1), .is_in_delayslot_o(ids1), .bad_addr_o(bad1),
    .flush_o(fl1), .newpc_o(np1));
  exc_commit_unit #(.FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .stall_i(stall), .inst_valid_i(valid3), .pc_i(pc),
    .in_delayslot_i(ds), .mem_addr_i(mem), .exc_flags_i(flags), .adel_if_i(adel_if),
    .cp0_status_i(status), .cp0_cause_i(cause), .cp0_epc_i(epc), .wb_cp0_we_i(we),
    .wb_cp0_waddr_i(waddr), .wb_cp0_wdata_i(wdata), .excepttype_o(et3),
    .current_inst_addr_o(addr3), .is_in_delayslot_o(ids3), .bad_addr_o(bad3),
    .flush_o(fl3), .newpc_o(np3));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push1(input logic [31:0] c, input logic [31:0] a, input logic d,
                       input logic [31:0] b, input logic [31:0] n);
    exp_t e;
    e = '{code: c, addr: a, ds: d, bad: b, newpc: n};
    q1.push_back(e);
  endtask
  task automatic push3(input logic [31:0] c, input logic [31:0] a, input logic [31:0] n);
    exp_t e;
    e = '{code: c, addr: a, ds: 1'b0, bad: 32'h0, newpc: n};
    q3.push_back(e);
  endtask
  task automatic clear_inputs();
    stall = 0; valid = 0; valid3 = 0; ds = 0; adel_if = 0; we = 0;
    flags = 0; pc = 0; mem = 0; status = 0; cause = 0; epc = 0; wdata = 0; waddr = 0;
  endtask
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst && et1 != 0) begin
      if (q1.size() == 0) check("unexpected_pulse", et1, 32'h0);
      else begin
        e = q1.pop_front();
        check("code", et1, e.code);
        check("inst_addr", addr1, e.addr);
        check("delayslot", {31'h0, ids1}, {31'h0, e.ds});
        check("bad_addr", bad1, e.bad);
        check("flush_on_pulse", {31'h0, fl1}, 32'h1);
        check("newpc", np1, e.newpc);
      end
    end
  end
  always @(negedge clk) begin : mon3
    exp_t e;
    if (rst && et3 != 0) begin
      if (q3.size() == 0) check("unexpected_pulse3", et3, 32'h0);
      else begin
        e = q3.pop_front();
        check("code3", et3, e.code);
        check("inst_addr3", addr3, e.addr);
        check("flush3_on_pulse", {31'h0, fl3}, 32'h1);
        check("newpc3", np3, e.newpc);
      end
    end
  end
  initial begin
    clear_inputs();
    valid = 1; flags = 8'hff;
    step(); step();
    @(negedge clk);
    check("reset_excepttype", et1, 32'h0);
    check("reset_flush", {31'h0, fl1}, 32'h0);
    step();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    check("idle_excepttype", et1, 32'h0);
    check("idle_newpc", np1, 32'h0);
    step();
    valid = 1; pc = 32'hBFC00100; flags = 8'h02;
    push1(32'h0c, 32'hBFC00100, 1'b0, 32'h0, VEC);
    step();
    pc = 32'h80000010; mem = 32'h80000123; ds = 1; flags = 8'h41;
    push1(32'h0a, 32'h80000010, 1'b1, 32'h0, VEC);
    step();
    clear_inputs();
    @(negedge clk);
    check("single_pulse", et1, 32'h0);
    step();
    valid = 1; flags = 8'h04; pc = 32'h80000200; stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_excepttype", et1, 32'h0);
      check("hold_flush", {31'h0, fl1}, 32'h0);
      step();
      flags = 8'h02; pc = 32'h80000ff0;
    end
    stall = 0; valid = 0; flags = 0;
    push1(32'h08, 32'h80000200, 1'b0, 32'h0, VEC);
    step();
    @(negedge clk);
    check("after_release", et1, 32'h0);
    step();
    status = 32'h0000_0401; cause = 32'h0000_0400; pc = 32'h80000300;
    @(negedge clk);
    check("int_bubble", et1, 32'h0);
    step();
    valid = 1;
    push1(32'h01, 32'h80000300, 1'b0, 32'h0, VEC);
    step();
    status = 32'h0000_0403;
    @(negedge clk);
    check("int_exl_masked", et1, 32'h0);
    step();
    clear_inputs();
    valid = 1; flags = 8'h20; pc = 32'h80000400; epc = 32'h12345678;
    we = 1; waddr = 5'd14; wdata = 32'h80001000;
    push1(32'h0e, 32'h80000400, 1'b0, 32'h0, 32'h80001000);
    step();
    clear_inputs();
    valid = 1; adel_if = 1; flags = 8'h02; pc = 32'h80000502;
    push1(32'h04, 32'h80000502, 1'b0, 32'h80000502, VEC);
    step();
    clear_inputs();
    valid = 1; flags = 8'h80; pc = 32'h80000600; mem = 32'h80000a01;
    push1(32'h05, 32'h80000600, 1'b0, 32'h80000a01, VEC);
    step();
    clear_inputs();
    valid = 1; pc = 32'h80000610; cause = 32'h0000_0400; we = 1; waddr = 5'd12; wdata = 32'h0000_0401;
    push1(32'h01, 32'h80000610, 1'b0, 32'h0, VEC);
    step();
    cause = 0; status = 32'h0000_0101; waddr = 5'd13; wdata = 32'h0000_ff00; pc = 32'h80000620;
    push1(32'h01, 32'h80000620, 1'b0, 32'h0, VEC);
    step();
    status = 32'h0000_8001; wdata = 32'h0000_8000;
    @(negedge clk);
    check("cause_fwd_ip_mask", et1, 32'h0);
    step();
    clear_inputs();
    valid = 1; flags = 8'h38; pc = 32'h80000630;
    push1(32'h09, 32'h80000630, 1'b0, 32'h0, VEC);
    step();
    clear_inputs();
    valid3 = 1; flags = 8'h08; pc = 32'h80000700;
    push3(32'h09, 32'h80000700, VEC);
    @(negedge clk);
    check("flush3_c0", {31'h0, fl3}, 32'h1);
    step();
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check("flush3_held", {31'h0, fl3}, 32'h1);
      check("flush3_code0", et3, 32'h0);
      check("flush3_newpc", np3, VEC);
      step();
    end
    valid3 = 0;
    @(negedge clk);
    check("flush3_end", {31'h0, fl3}, 32'h0);
    step();
    valid3 = 1; pc = 32'h80000800;
    push3(32'h09, 32'h80000800, VEC);
    step();
    valid3 = 0; rst = 0;
    step();
    rst = 1;
    @(negedge clk);
    check("flush3_after_rst", {31'h0, fl3}, 32'h0);
    check("newpc3_after_rst", np3, 32'h0);
    step(); step();
    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
